dllp_rx_vc: RTL and testbench
=============================

DLLP_RX_VC -- requirements
Module: dllp_rx_vc

Interface
REQ-001 SHALL have parameter VC_COUNT, default 1, number of supported virtual channels (legal range 1..8).
REQ-002 SHALL have parameter USER_WIDTH, default 4, sideband width; tuser[0]=1 marks a DLLP beat.
REQ-003 SHALL have port clk_i  input  1  the single clock; one clock domain, all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port phy_link_up_i  input  1  physical link up.
REQ-006 SHALL have ports s_axis_tdata/tkeep/tvalid/tlast/tuser/tready  in/in/in/in/in/out  32/4/1/1/USER_WIDTH/1  DLLP stream from phy; byte0 = tdata[7:0].
REQ-007 SHALL have ports seq_num_o/seq_num_vld_o/seq_num_acknack_o  output  12/1/1  Ack/Nak sequence, 1-cycle valid pulse, 1=Ack 0=Nak.
REQ-008 SHALL have ports tx_fc_ph_o, tx_fc_nph_o, tx_fc_cplh_o  output  VC_COUNT*8 each  per-VC header credits, VC n at bits [8n+7:8n].
REQ-009 SHALL have ports tx_fc_pd_o, tx_fc_npd_o, tx_fc_cpld_o  output  VC_COUNT*12 each  per-VC data credits, VC n at [12n+11:12n].
REQ-010 SHALL have ports fc1_values_stored_o/fc2_values_stored_o/update_fc_o  output  VC_COUNT each  per-VC InitFC1 done, InitFC2 done, UpdateFC pulse.
REQ-011 SHALL have ports dllp_err_o/crc_err_o  output  1/1  malformed-or-unsupported-VC pulse, CRC failure pulse.

Function
REQ-012 SHALL hold s_axis_tready=1 in all states outside reset; beats with tuser[0]=0 SHALL be consumed and ignored.
REQ-013 SHALL accept a DLLP as two beats: beat0 tkeep=4'hF tlast=0 (DLLP bytes 0-3), beat1 tkeep=4'h3 tlast=1 (CRC bytes, byte4=tdata[7:0]).
REQ-014 SHALL implement FSM S_HDR -> S_CRC on valid beat0; S_CRC -> S_HDR on beat1 with tlast; any other shape -> S_DROP until a tlast beat, then S_HDR; each drop pulses dllp_err_o once.
REQ-015 SHALL decode byte0: 0x00 Ack, 0x10 Nak, 0x40/0x50/0x60 InitFC1 P/NP/Cpl, 0xC0/0xD0/0xE0 InitFC2, 0x80/0x90/0xA0 UpdateFC; low 3 bits of FC types = VC id; other types ignored silently.
REQ-016 SHALL extract seq = {byte2[3:0],byte3}, HdrFC = {byte1[5:0],byte2[7:6]}, DataFC = {byte2[3:0],byte3}.
REQ-017 SHALL apply all output updates registered, exactly one cycle after the accepted beat1.
REQ-018 SHALL, for InitFC1/InitFC2, write that type's Hdr/Data credits of the addressed VC and set a per-VC-per-type received bit; fc1_values_stored_o[n] SHALL set when P, NP and Cpl InitFC1 (or any InitFC2) for VC n have all been received; fc2_values_stored_o[n] SHALL set on the first InitFC2 of VC n once fc1 is set.
REQ-019 SHALL apply UpdateFC only when fc1_values_stored_o[n]=1, pulsing update_fc_o[n]; otherwise discard with no pulse.
REQ-020 SHALL discard FC DLLPs with VC id >= VC_COUNT and pulse dllp_err_o.
REQ-021 SHALL, while phy_link_up_i=0, clear all credits and fc1/fc2 flags synchronously and ignore all DLLPs; FSM returns to S_HDR.
REQ-022 SHALL overwrite (not accumulate) credits; 8/12-bit values are stored verbatim, wrap-around handled by consumer.

Reset
REQ-023 SHALL, on rst_i assertion (async), force FSM to S_HDR, all credit outputs, flags and pulses to 0, seq_num_o to 12'h000; a partial DLLP in flight SHALL be lost without error pulse.

Configuration
REQ-024 SHALL, with macro DLLP_CRC_CHECK_EN defined, compute PCIe LCRC-16 (poly 0x100B, seed 0xFFFF) over bytes 0-3, compare with bytes 4-5, and on mismatch drop the DLLP and pulse crc_err_o; without it, CRC bytes SHALL be ignored and crc_err_o tied 0.

Verification
REQ-025 Ack seq 0x123 (bytes 00 00 01 23) -> next cycle seq_num_o=0x123, vld=1 for 1 cycle, acknack=1.
REQ-026 VC_COUNT=2: InitFC1 P/NP/Cpl on VC1 with HdrFC=0x20, DataFC=0x100 -> fc1_values_stored_o=2'b10, tx_fc_ph_o[15:8]=0x20, tx_fc_pd_o[23:12]=0x100.
REQ-027 UpdateFC-P on VC0 before InitFC1 -> no update_fc_o, credits stay 0; after init -> update_fc_o=2'b01 and new value.
REQ-028 InitFC1 on VC5 with VC_COUNT=2 -> dllp_err_o pulse, no state change; beat0 with tlast=1 -> dllp_err_o pulse, FSM back to S_HDR.
REQ-029 DLLP_CRC_CHECK_EN defined, Ack with corrupted CRC -> crc_err_o pulse, seq_num_vld_o stays 0; undefined -> Ack accepted.
REQ-030 rst_i asserted between beat0 and beat1, then valid Nak 0x7FF -> only Nak reported, acknack=0, seq_num_o=0x7FF.

Source files
------------

// File: rtl/dllp_rx_vc.sv
// dllp_rx_vc: receives two-beat PCIe DLLPs from the phy stream, reports Ack/Nak
// sequence numbers and keeps per-VC transmit flow-control credits.
// Optional feature: define DLLP_CRC_CHECK_EN to verify the LCRC-16 of each DLLP.
module dllp_rx_vc #(
  parameter int unsigned VC_COUNT   = 1,
  parameter int unsigned USER_WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     phy_link_up_i,
  input  logic [31:0]              s_axis_tdata,
  input  logic [3:0]               s_axis_tkeep,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser,
  output logic                     s_axis_tready,
  output logic [11:0]              seq_num_o,
  output logic                     seq_num_vld_o,
  output logic                     seq_num_acknack_o,
  output logic [VC_COUNT*8-1:0]    tx_fc_ph_o,
  output logic [VC_COUNT*8-1:0]    tx_fc_nph_o,
  output logic [VC_COUNT*8-1:0]    tx_fc_cplh_o,
  output logic [VC_COUNT*12-1:0]   tx_fc_pd_o,
  output logic [VC_COUNT*12-1:0]   tx_fc_npd_o,
  output logic [VC_COUNT*12-1:0]   tx_fc_cpld_o,
  output logic [VC_COUNT-1:0]      fc1_values_stored_o,
  output logic [VC_COUNT-1:0]      fc2_values_stored_o,
  output logic [VC_COUNT-1:0]      update_fc_o,
  output logic                     dllp_err_o,
  output logic                     crc_err_o
);

  typedef enum logic [1:0] {S_HDR, S_CRC, S_DROP} state_t;

  state_t                  state_q, state_d;
  logic                    rdy_q;
  logic [31:0]             hdr_q, hdr_d;
  logic [11:0]             seq_q, seq_d;
  logic                    seq_vld_q, seq_vld_d;
  logic                    acknack_q, acknack_d;
  logic [VC_COUNT*8-1:0]   ph_q, ph_d, nph_q, nph_d, cplh_q, cplh_d;
  logic [VC_COUNT*12-1:0]  pd_q, pd_d, npd_q, npd_d, cpld_q, cpld_d;
  logic [VC_COUNT-1:0]     got_p_q, got_p_d, got_np_q, got_np_d, got_cpl_q, got_cpl_d;
  logic [VC_COUNT-1:0]     fc1_q, fc1_d, fc2_q, fc2_d, upd_q, upd_d;
  logic                    dllp_err_q, dllp_err_d;
  logic                    crc_err_q, crc_err_d;

  logic       beat, shape0, shape1, crc_ok;
  logic [7:0] b0, b1, b2, b3;
  logic [2:0] vc;
  logic       vc_ok, is_fc, is_init1, is_init2, is_upd;
  logic [7:0] hdr_fc;
  logic [11:0] data_fc;
  logic       unused_tuser;

  assign unused_tuser = ^s_axis_tuser[USER_WIDTH-1:1];

  assign beat   = s_axis_tvalid & rdy_q & s_axis_tuser[0];
  assign shape0 = (s_axis_tkeep == 4'hF) & ~s_axis_tlast;
  assign shape1 = (s_axis_tkeep == 4'h3) & s_axis_tlast;

  assign b0 = hdr_q[7:0];
  assign b1 = hdr_q[15:8];
  assign b2 = hdr_q[23:16];
  assign b3 = hdr_q[31:24];

  assign vc       = b0[2:0];
  assign vc_ok    = ({29'd0, vc} < VC_COUNT);
  assign is_fc    = ~b0[3] & (b0[7:6] != 2'b00) & (b0[5:4] != 2'b11);
  assign is_init1 = is_fc & (b0[7:6] == 2'b01);
  assign is_init2 = is_fc & (b0[7:6] == 2'b11);
  assign is_upd   = is_fc & (b0[7:6] == 2'b10);
  assign hdr_fc   = {b1[5:0], b2[7:6]};
  assign data_fc  = {b2[3:0], b3};

`ifdef DLLP_CRC_CHECK_EN
  // Bit-serial LCRC-16, each byte MSB first, result inverted; byte4 carries the high half.
  function automatic logic [15:0] lcrc16(input logic [31:0] d);
    logic [15:0] c;
    logic        fb;
    c = '1;
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        fb = c[15] ^ d[8*i + 7 - j];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h100B;
      end
    end
    return ~c;
  endfunction

  assign crc_ok = (lcrc16(hdr_q) == {s_axis_tdata[7:0], s_axis_tdata[15:8]});
`else
  assign crc_ok = 1'b1;
`endif

  // Beat framing FSM, DLLP decode and credit/flag next-state.
  always_comb begin
    logic done;
    done       = 1'b0;
    state_d    = state_q;
    hdr_d      = hdr_q;
    seq_d      = seq_q;
    seq_vld_d  = 1'b0;
    acknack_d  = acknack_q;
    ph_d       = ph_q;
    nph_d      = nph_q;
    cplh_d     = cplh_q;
    pd_d       = pd_q;
    npd_d      = npd_q;
    cpld_d     = cpld_q;
    got_p_d    = got_p_q;
    got_np_d   = got_np_q;
    got_cpl_d  = got_cpl_q;
    fc1_d      = fc1_q;
    fc2_d      = fc2_q;
    upd_d      = '0;
    dllp_err_d = 1'b0;
    crc_err_d  = 1'b0;

    if (beat) begin
      unique case (state_q)
        S_HDR: begin
          if (shape0) begin
            hdr_d   = s_axis_tdata;
            state_d = S_CRC;
          end else begin
            dllp_err_d = 1'b1;
            state_d    = s_axis_tlast ? S_HDR : S_DROP;
          end
        end
        S_CRC: begin
          if (shape1) begin
            state_d = S_HDR;
            if (crc_ok) done = 1'b1;
            else        crc_err_d = 1'b1;
          end else begin
            dllp_err_d = 1'b1;
            state_d    = s_axis_tlast ? S_HDR : S_DROP;
          end
        end
        S_DROP: begin
          if (s_axis_tlast) state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end

    if (done) begin
      if (b0 == 8'h00 || b0 == 8'h10) begin
        seq_d     = {b2[3:0], b3};
        seq_vld_d = 1'b1;
        acknack_d = (b0 == 8'h00);
      end else if (is_fc) begin
        if (!vc_ok) begin
          dllp_err_d = 1'b1;
        end else begin
          for (int unsigned n = 0; n < VC_COUNT; n++) begin
            if ({29'd0, vc} == n && (!is_upd || fc1_q[n])) begin
              unique case (b0[5:4])
                2'b00: begin
                  ph_d[n*8 +: 8]   = hdr_fc;
                  pd_d[n*12 +: 12] = data_fc;
                  if (!is_upd) got_p_d[n] = 1'b1;
                end
                2'b01: begin
                  nph_d[n*8 +: 8]   = hdr_fc;
                  npd_d[n*12 +: 12] = data_fc;
                  if (!is_upd) got_np_d[n] = 1'b1;
                end
                default: begin
                  cplh_d[n*8 +: 8]   = hdr_fc;
                  cpld_d[n*12 +: 12] = data_fc;
                  if (!is_upd) got_cpl_d[n] = 1'b1;
                end
              endcase
              if (is_upd) begin
                upd_d[n] = 1'b1;
              end else begin
                // fc2 qualifies on fc1 as it stood before this DLLP
                fc2_d[n] = fc2_q[n] | (is_init2 & fc1_q[n]);
                fc1_d[n] = fc1_q[n] | is_init2 |
                           (is_init1 & got_p_d[n] & got_np_d[n] & got_cpl_d[n]);
              end
            end
          end
        end
      end
    end

    if (!phy_link_up_i) begin
      state_d    = S_HDR;
      seq_d      = seq_q;
      seq_vld_d  = 1'b0;
      acknack_d  = acknack_q;
      ph_d       = '0;
      nph_d      = '0;
      cplh_d     = '0;
      pd_d       = '0;
      npd_d      = '0;
      cpld_d     = '0;
      got_p_d    = '0;
      got_np_d   = '0;
      got_cpl_d  = '0;
      fc1_d      = '0;
      fc2_d      = '0;
      upd_d      = '0;
      dllp_err_d = 1'b0;
      crc_err_d  = 1'b0;
    end
  end

  // State and output registers; reset discards any partial DLLP silently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_HDR;
      rdy_q      <= 1'b0;
      hdr_q      <= '0;
      seq_q      <= '0;
      seq_vld_q  <= 1'b0;
      acknack_q  <= 1'b0;
      ph_q       <= '0;
      nph_q      <= '0;
      cplh_q     <= '0;
      pd_q       <= '0;
      npd_q      <= '0;
      cpld_q     <= '0;
      got_p_q    <= '0;
      got_np_q   <= '0;
      got_cpl_q  <= '0;
      fc1_q      <= '0;
      fc2_q      <= '0;
      upd_q      <= '0;
      dllp_err_q <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      hdr_q      <= hdr_d;
      seq_q      <= seq_d;
      seq_vld_q  <= seq_vld_d;
      acknack_q  <= acknack_d;
      ph_q       <= ph_d;
      nph_q      <= nph_d;
      cplh_q     <= cplh_d;
      pd_q       <= pd_d;
      npd_q      <= npd_d;
      cpld_q     <= cpld_d;
      got_p_q    <= got_p_d;
      got_np_q   <= got_np_d;
      got_cpl_q  <= got_cpl_d;
      fc1_q      <= fc1_d;
      fc2_q      <= fc2_d;
      upd_q      <= upd_d;
      dllp_err_q <= dllp_err_d;
      crc_err_q  <= crc_err_d;
    end
  end

  assign s_axis_tready       = rdy_q;
  assign seq_num_o           = seq_q;
  assign seq_num_vld_o       = seq_vld_q;
  assign seq_num_acknack_o   = acknack_q;
  assign tx_fc_ph_o          = ph_q;
  assign tx_fc_nph_o         = nph_q;
  assign tx_fc_cplh_o        = cplh_q;
  assign tx_fc_pd_o          = pd_q;
  assign tx_fc_npd_o         = npd_q;
  assign tx_fc_cpld_o        = cpld_q;
  assign fc1_values_stored_o = fc1_q;
  assign fc2_values_stored_o = fc2_q;
  assign update_fc_o         = upd_q;
  assign dllp_err_o          = dllp_err_q;
  assign crc_err_o           = crc_err_q;

endmodule

// File: tb/tb_dllp_rx_vc.sv
// tb_dllp_rx_vc: directed scoreboard bench for dllp_rx_vc with two VCs.
module tb_dllp_rx_vc;
  localparam int unsigned VCN = 2;
  localparam int unsigned UW  = 4;

  logic            clk = 1'b0;
  logic            rst, link;
  logic [31:0]     tdata;
  logic [3:0]      tkeep;
  logic            tvalid, tlast;
  logic [UW-1:0]   tuser;
  logic            tready;
  logic [11:0]     seq_num;
  logic            seq_vld, seq_an;
  logic [VCN*8-1:0]  ph, nph, cplh;
  logic [VCN*12-1:0] pd, npd, cpld;
  logic [VCN-1:0]  fc1, fc2, upd;
  logic            derr, cerr;

  always #5 clk = ~clk;

  dllp_rx_vc #(.VC_COUNT(VCN), .USER_WIDTH(UW)) dut (
    .clk_i(clk), .rst_i(rst), .phy_link_up_i(link),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser), .s_axis_tready(tready),
    .seq_num_o(seq_num), .seq_num_vld_o(seq_vld), .seq_num_acknack_o(seq_an),
    .tx_fc_ph_o(ph), .tx_fc_nph_o(nph), .tx_fc_cplh_o(cplh),
    .tx_fc_pd_o(pd), .tx_fc_npd_o(npd), .tx_fc_cpld_o(cpld),
    .fc1_values_stored_o(fc1), .fc2_values_stored_o(fc2), .update_fc_o(upd),
    .dllp_err_o(derr), .crc_err_o(cerr)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [11:0] seq;
    logic        vld, an;
    logic [15:0] ph, nph, cplh;
    logic [23:0] pd, npd, cpld;
    logic [1:0]  fc1, fc2, upd;
    logic        derr, cerr;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  logic [7:0]     m_hc [3][VCN];
  logic [11:0]    m_dc [3][VCN];
  logic [VCN-1:0] m_got [3];
  logic [VCN-1:0] m_fc1, m_fc2;
  logic [11:0]    m_seq;
  logic           m_an;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_fc();
    for (int t = 0; t < 3; t++) begin
      for (int v = 0; v < VCN; v++) begin
        m_hc[t][v] = '0;
        m_dc[t][v] = '0;
      end
      m_got[t] = '0;
    end
    m_fc1 = '0;
    m_fc2 = '0;
  endtask

  task automatic expect_out(input string tag, input logic vld, input logic [1:0] u,
                            input logic de, input logic ce);
    exp_t e;
    e.tag  = tag;
    e.seq  = m_seq;
    e.vld  = vld;
    e.an   = m_an;
    e.ph   = {m_hc[0][1], m_hc[0][0]};
    e.nph  = {m_hc[1][1], m_hc[1][0]};
    e.cplh = {m_hc[2][1], m_hc[2][0]};
    e.pd   = {m_dc[0][1], m_dc[0][0]};
    e.npd  = {m_dc[1][1], m_dc[1][0]};
    e.cpld = {m_dc[2][1], m_dc[2][0]};
    e.fc1  = m_fc1;
    e.fc2  = m_fc2;
    e.upd  = u;
    e.derr = de;
    e.cerr = ce;
    sb.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".seq"},  seq_num, e.seq);
      chk({e.tag, ".vld"},  seq_vld, e.vld);
      chk({e.tag, ".an"},   seq_an,  e.an);
      chk({e.tag, ".ph"},   ph,      e.ph);
      chk({e.tag, ".nph"},  nph,     e.nph);
      chk({e.tag, ".cplh"}, cplh,    e.cplh);
      chk({e.tag, ".pd"},   pd,      e.pd);
      chk({e.tag, ".npd"},  npd,     e.npd);
      chk({e.tag, ".cpld"}, cpld,    e.cpld);
      chk({e.tag, ".fc1"},  fc1,     e.fc1);
      chk({e.tag, ".fc2"},  fc2,     e.fc2);
      chk({e.tag, ".upd"},  upd,     e.upd);
      chk({e.tag, ".derr"}, derr,    e.derr);
      chk({e.tag, ".cerr"}, cerr,    e.cerr);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    tvalid = 1'b0;
    tlast  = 1'b0;
    tkeep  = '0;
    tdata  = '0;
    tuser  = '0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u0);
    chk("tready", tready, 1'b1);
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tuser  = {3'b010, u0};
    tvalid = 1'b1;
  endtask

  function automatic logic [15:0] tb_crc(input logic [7:0] by [4]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ by[i][j];
        c  = c << 1;
        if (fb) c = c ^ 16'h100B;
      end
    end
    return ~c;
  endfunction

  task automatic quiet(input string tag);
    expect_out(tag, 1'b0, 2'b00, 1'b0, 1'b0);
    compare_now();
  endtask

  // Send one well-framed DLLP, check the cycle after beat1, then check pulses dropped.
  task automatic run(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                     input logic [7:0] a2, input logic [7:0] a3, input logic corrupt,
                     input logic vld, input logic [1:0] u, input logic de, input logic ce);
    logic [7:0]  by [4];
    logic [15:0] c;
    by[0] = a0; by[1] = a1; by[2] = a2; by[3] = a3;
    c = tb_crc(by);
    if (corrupt) c = c ^ 16'h0001;
    tick(); beat({a3, a2, a1, a0}, 4'hF, 1'b0, 1'b1);
    expect_out(tag, vld, u, de, ce);
    tick(); beat({16'h0000, c[7:0], c[15:8]}, 4'h3, 1'b1, 1'b1);
    tick(); idle(); compare_now();
    tick(); quiet({tag, ".after"});
  endtask

  task automatic do_seq(input string tag, input logic [11:0] s, input logic ack);
    m_seq = s;
    m_an  = ack;
    run(tag, ack ? 8'h00 : 8'h10, 8'h00, {4'h0, s[11:8]}, s[7:0], 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
  endtask

  // kind: 0 InitFC1, 1 InitFC2, 2 UpdateFC; t: 0 P, 1 NP, 2 Cpl
  task automatic do_fc(input string tag, input int kind, input int t, input logic [2:0] vc,
                       input logic [7:0] h, input logic [11:0] d);
    logic [7:0] base, a0;
    logic [1:0] u;
    logic       de, prev1;
    base = (kind == 0) ? 8'h40 : (kind == 1) ? 8'hC0 : 8'h80;
    a0   = base + 8'(t * 16) + {5'd0, vc};
    u    = 2'b00;
    de   = 1'b0;
    if (int'(vc) >= VCN) begin
      de = 1'b1;
    end else if (kind == 2) begin
      if (m_fc1[vc]) begin
        m_hc[t][vc] = h;
        m_dc[t][vc] = d;
        u[vc] = 1'b1;
      end
    end else begin
      m_hc[t][vc]  = h;
      m_dc[t][vc]  = d;
      m_got[t][vc] = 1'b1;
      prev1 = m_fc1[vc];
      if (kind == 1) m_fc2[vc] = m_fc2[vc] | prev1;
      m_fc1[vc] = prev1 | (kind == 1) | (m_got[0][vc] & m_got[1][vc] & m_got[2][vc]);
    end
    run(tag, a0, {2'b00, h[7:2]}, {h[1:0], 2'b00, d[11:8]}, d[7:0], 1'b0, 1'b0, u, de, 1'b0);
  endtask

  initial begin
    logic [7:0] gb [4];
    logic [15:0] gc;
    rst = 1'b1;
    link = 1'b1;
    idle();
    model_clear_fc();
    m_seq = '0;
    m_an  = 1'b0;
    repeat (3) tick();
    chk("reset.tready", tready, 1'b0);
    quiet("reset");
    rst = 1'b0;
    tick();

    do_seq("ack123", 12'h123, 1'b1);
    do_fc("upd_p_vc0_preinit", 2, 0, 3'd0, 8'h11, 12'h022);
    do_fc("fc1_p_vc1",   0, 0, 3'd1, 8'h20, 12'h100);
    do_fc("fc1_np_vc1",  0, 1, 3'd1, 8'h20, 12'h100);
    do_fc("fc1_cpl_vc1", 0, 2, 3'd1, 8'h20, 12'h100);
    do_fc("fc1_p_vc0",   0, 0, 3'd0, 8'h05, 12'h0AB);
    do_fc("fc1_np_vc0",  0, 1, 3'd0, 8'h06, 12'h0CD);
    do_fc("fc1_cpl_vc0", 0, 2, 3'd0, 8'hFF, 12'hFFF);
    do_fc("upd_p_vc0",   2, 0, 3'd0, 8'h3C, 12'h123);
    do_fc("fc2_np_vc1",  1, 1, 3'd1, 8'h33, 12'h444);
    do_fc("fc1_p_vc5",   0, 0, 3'd5, 8'h77, 12'h777);
    do_fc("upd_cpl_vc1", 2, 2, 3'd1, 8'h01, 12'h002);
    do_seq("nak_zero", 12'h000, 1'b0);

    // beat0 carrying tlast: one error pulse, back to header hunting
    tick(); beat(32'h2301_0000, 4'hF, 1'b1, 1'b1);
    expect_out("bad_b0", 1'b0, 2'b00, 1'b1, 1'b0);
    tick(); idle(); compare_now();
    tick(); quiet("bad_b0.after");

    // beat1 without tlast: error once, drop until tlast with no further pulse
    tick(); beat(32'h5501_0000, 4'hF, 1'b0, 1'b1);
    tick(); beat(32'h0000_1234, 4'hF, 1'b0, 1'b1);
    expect_out("bad_b1", 1'b0, 2'b00, 1'b1, 1'b0);
    tick(); compare_now(); beat(32'h0000_5678, 4'h3, 1'b1, 1'b1);
    tick(); idle(); quiet("drop_end");
    do_seq("ack_after_drop", 12'hABC, 1'b1);

    // non-DLLP beat between the two halves is ignored
    gb[0] = 8'h10; gb[1] = 8'h00; gb[2] = 8'h04; gb[3] = 8'h56;
    gc = tb_crc(gb);
    m_seq = 12'h456;
    m_an  = 1'b0;
    tick(); beat({gb[3], gb[2], gb[1], gb[0]}, 4'hF, 1'b0, 1'b1);
    tick(); beat(32'hDEAD_BEEF, 4'h1, 1'b1, 1'b0);
    expect_out("tuser_gap", 1'b1, 2'b00, 1'b0, 1'b0);
    tick(); beat({16'h0000, gc[7:0], gc[15:8]}, 4'h3, 1'b1, 1'b1);
    tick(); idle(); compare_now();
    tick(); quiet("tuser_gap.after");

`ifdef DLLP_CRC_CHECK_EN
    run("ack_badcrc", 8'h00, 8'h00, 8'h0F, 8'hFF, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
`else
    m_seq = 12'hFFF;
    m_an  = 1'b1;
    run("ack_badcrc", 8'h00, 8'h00, 8'h0F, 8'hFF, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
`endif

    // link down clears credits and flags, ignores traffic
    link = 1'b0;
    model_clear_fc();
    tick(); quiet("link_down");
    run("fc_link_down", 8'h40, 8'h08, 8'h01, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    link = 1'b1;
    tick();
    do_fc("fc2_p_vc1_relink", 1, 0, 3'd1, 8'h44, 12'h555);

    // reset lands between beat0 and beat1
    tick(); beat(32'h5505_0000, 4'hF, 1'b0, 1'b1);
    tick(); idle(); rst = 1'b1;
    tick(); rst = 1'b0;
    model_clear_fc();
    m_seq = '0;
    m_an  = 1'b0;
    quiet("mid_reset");
    tick(); quiet("mid_reset.after");
    do_seq("nak7ff", 12'h7FF, 1'b0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
